// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter/sequencer for single-port data memory
//
// Shares one single-port data memory between the core load/store port (cpu_*)
// and the host loading/debug port (ext_*). Each transaction follows a fixed
// three-cycle sequence: grant in IDLE, one memory cycle in ACCESS, and a
// one-cycle rvalid pulse to the owner in RESP.
//
// Parameters:
//   ADDR_W  address width
//   DATA_W  data width
// Ports:
//   clk, reset           clock; asynchronous active-low reset
//   cpu_req/we/addr/wdata   core request; held stable until cpu_gnt
//   cpu_gnt              request accepted this cycle (combinational, IDLE only)
//   cpu_rvalid/rdata     completion pulse and captured read data
//   ext_*                same set for the host port
//   mem_we/addr/wdata    memory request, driven only during ACCESS
//   mem_rdata            combinational read data from memory
//   cpu_cnt, ext_cnt     accepted-transaction counters
// Build option:
//   DMEM_ARB_STATS_EN    when defined, cpu_cnt/ext_cnt are saturating counters;
//                        otherwise both outputs are tied to zero.

module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       cpu_cnt,
    output logic [15:0]       ext_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_EXT = 1'b1;

    state_t            state;
    state_t            state_nxt;
    logic              owner_q;
    logic              last_owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] ext_rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grants are only possible in IDLE and are mutually exclusive: under a
    // tie the port that did not own the previous transaction wins.
    always_comb begin
        state_nxt  = state;
        cpu_gnt    = 1'b0;
        ext_gnt    = 1'b0;
        cpu_rvalid = 1'b0;
        ext_rvalid = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            ST_IDLE: begin
                cpu_gnt = cpu_req && (!ext_req || last_owner_q == OWN_EXT);
                ext_gnt = ext_req && (!cpu_req || last_owner_q == OWN_CPU);
                if (cpu_gnt || ext_gnt) begin
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                cpu_rvalid = (owner_q == OWN_CPU);
                ext_rvalid = (owner_q == OWN_EXT);
                state_nxt  = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request latches: captured on the accepting edge so the requester may
    // drop or change its inputs right after the grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q      <= OWN_CPU;
            last_owner_q <= OWN_EXT;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else if (cpu_gnt) begin
            owner_q      <= OWN_CPU;
            last_owner_q <= OWN_CPU;
            we_q         <= cpu_we;
            addr_q       <= cpu_addr;
            wdata_q      <= cpu_wdata;
        end else if (ext_gnt) begin
            owner_q      <= OWN_EXT;
            last_owner_q <= OWN_EXT;
            we_q         <= ext_we;
            addr_q       <= ext_addr;
            wdata_q      <= ext_wdata;
        end
    end

    // Read data is captured for writes as well (old memory contents), and
    // each port keeps its value until its own next ACCESS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
        end else if (state == ST_ACCESS) begin
            if (owner_q == OWN_CPU) begin
                cpu_rdata_q <= mem_rdata;
            end else begin
                ext_rdata_q <= mem_rdata;
            end
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign ext_rdata = ext_rdata_q;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] cpu_cnt_q;
    logic [15:0] ext_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_cnt_q <= '0;
            ext_cnt_q <= '0;
        end else begin
            if (cpu_gnt && cpu_cnt_q != 16'hFFFF) begin
                cpu_cnt_q <= cpu_cnt_q + 16'd1;
            end
            if (ext_gnt && ext_cnt_q != 16'hFFFF) begin
                ext_cnt_q <= ext_cnt_q + 16'd1;
            end
        end
    end

    assign cpu_cnt = cpu_cnt_q;
    assign ext_cnt = ext_cnt_q;
`else
    assign cpu_cnt = '0;
    assign ext_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter

module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        ext_req = 1'b0;
    logic        ext_we = 1'b0;
    logic [31:0] ext_addr = '0;
    logic [31:0] ext_wdata = '0;
    logic        ext_gnt;
    logic        ext_rvalid;
    logic [31:0] ext_rdata;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [15:0] cpu_cnt;
    logic [15:0] ext_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_cnt(cpu_cnt), .ext_cnt(ext_cnt)
    );

    // Memory model: unwritten words read 0xDEADBEEF at 0x10, else 0x5A5A0000 ^ addr.
    logic [31:0] mem [0:63];
    logic [63:0] mem_vld = '0;
    logic [5:0]  mem_idx;
    assign mem_idx = mem_addr[7:2];
    assign mem_rdata = mem_vld[mem_idx] ? mem[mem_idx] :
                       (mem_addr == 32'h10) ? 32'hDEADBEEF : (32'h5A5A0000 ^ mem_addr);
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx]     <= mem_wdata;
            mem_vld[mem_idx] <= 1'b1;
        end
    end

    // Running event counts sampled away from the active edge.
    int we_cycles = 0;
    int ext_rv_cnt = 0;
    always @(negedge clk) begin
        if (mem_we) we_cycles <= we_cycles + 1;
        if (ext_rvalid) ext_rv_cnt <= ext_rv_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Waits (bounded) for the port's grant, sampled at the falling edge.
    task automatic wait_gnt(input bit ext, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ext ? ext_gnt : cpu_gnt) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, {31'd0, ok}, 32'd1);
    endtask

    // One complete transaction; starts and ends 1 time unit after a rising edge.
    task automatic do_txn(input bit ext, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input string tag);
        if (ext) begin
            ext_req = 1'b1; ext_we = we; ext_addr = addr; ext_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        wait_gnt(ext, {tag, "_gnt"});
        check({tag, "_gnt_excl"}, {31'd0, cpu_gnt & ext_gnt}, 32'd0);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        ext_req = 1'b0;
        @(negedge clk);
        check({tag, "_mem_addr"}, mem_addr, addr);
        check({tag, "_mem_we"}, {31'd0, mem_we}, {31'd0, we});
        check({tag, "_mem_wdata"}, mem_wdata, wdata);
        @(negedge clk);
        check({tag, "_rvalid"}, {30'd0, cpu_rvalid, ext_rvalid}, ext ? 32'd1 : 32'd2);
        check({tag, "_rdata"}, ext ? ext_rdata : cpu_rdata, exp_rdata);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int snap;

        // Reset values
        @(negedge clk);
        check("rst_gnt", {30'd0, cpu_gnt, ext_gnt}, 32'd0);
        check("rst_rvalid", {30'd0, cpu_rvalid, ext_rvalid}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_ext_rdata", ext_rdata, 32'd0);
        check("rst_cnt", {cpu_cnt, ext_cnt}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // CPU read alone
        do_txn(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, "cpu_rd");

        // Simultaneous requests straight out of reset: cpu, ext, cpu, ext
        apply_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20; cpu_wdata = '0;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h24; ext_wdata = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("tie_cpu_gnt_%0d", i), {31'd0, cpu_gnt}, (i % 6 == 0) ? 32'd1 : 32'd0);
            check($sformatf("tie_ext_gnt_%0d", i), {31'd0, ext_gnt}, (i % 6 == 3) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end
        cpu_req = 1'b0;
        ext_req = 1'b0;
        check("tie_cpu_rdata", cpu_rdata, 32'h5A5A0020);
        check("tie_ext_rdata", ext_rdata, 32'h5A5A0024);

        // Host write then CPU read-back
        snap = we_cycles;
        do_txn(1'b1, 1'b1, 32'h04, 32'h000000A5, 32'h5A5A0004, "ext_wr");
        check("ext_wr_we_cycles", we_cycles - snap, 32'd1);
        do_txn(1'b0, 1'b0, 32'h04, 32'h0, 32'h000000A5, "cpu_rdback");

        // Reset during ACCESS of a host write
        snap = ext_rv_cnt;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h08; ext_wdata = 32'h55;
        wait_gnt(1'b1, "racc_gnt");
        @(posedge clk);
        #1 ext_req = 1'b0;
        check("racc_we_before", {31'd0, mem_we}, 32'd1);
        #1 reset = 1'b0;
        #1;
        check("racc_we_dropped", {31'd0, mem_we}, 32'd0);
        check("racc_addr_cleared", mem_addr, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("racc_no_rvalid_now", {31'd0, ext_rvalid}, 32'd0);
        @(posedge clk);
        #1;
        check("racc_no_rvalid_total", ext_rv_cnt - snap, 32'd0);
        // Immediate grant shows IDLE; old data shows the write was not performed.
        do_txn(1'b0, 1'b0, 32'h08, 32'h0, 32'h5A5A0008, "racc_idle");

        // Withdrawn host request during a CPU ACCESS
        snap = ext_rv_cnt;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = '0;
        wait_gnt(1'b0, "wd_cpu_gnt");
        @(posedge clk);
        #1 cpu_req = 1'b0;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h0C; ext_wdata = 32'h77;
        @(negedge clk);
        check("wd_ext_gnt_acc", {31'd0, ext_gnt}, 32'd0);
        check("wd_mem_addr", mem_addr, 32'h10);
        @(posedge clk);
        #1 ext_req = 1'b0;
        @(negedge clk);
        check("wd_ext_gnt_resp", {31'd0, ext_gnt}, 32'd0);
        check("wd_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("wd_idle_gnt_%0d", i), {30'd0, cpu_gnt, ext_gnt}, 32'd0);
            check($sformatf("wd_idle_mem_%0d", i), {31'd0, mem_we} | mem_addr, 32'd0);
        end
        check("wd_ext_rvalid", ext_rv_cnt - snap, 32'd0);
        @(posedge clk);
        #1;
        do_txn(1'b0, 1'b0, 32'h0C, 32'h0, 32'h5A5A000C, "wd_no_write");

        // Transaction counters
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            do_txn(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, $sformatf("cnt_cpu%0d", i));
        end
        for (int i = 0; i < 3; i++) begin
            do_txn(1'b1, 1'b1, 32'h30 + 32'(4 * i), 32'(i), 32'h5A5A0030 + 32'(4 * i),
                   $sformatf("cnt_ext%0d", i));
        end
`ifdef DMEM_ARB_STATS_EN
        check("cpu_cnt", {16'd0, cpu_cnt}, 32'd5);
        check("ext_cnt", {16'd0, ext_cnt}, 32'd3);
`else
        check("cpu_cnt", {16'd0, cpu_cnt}, 32'd0);
        check("ext_cnt", {16'd0, ext_cnt}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
